// File: rtl/gold_code_gen.sv
// Gold-code chip generator: two Fibonacci LFSRs XORed into one chip per
// advance, with chip-rate prescaler, B seed load and programmable epoch.
module gold_code_gen #(
  parameter int unsigned    N         = 15,
  parameter logic [N-1:0]   TAPS_A    = 15'h0003,
  parameter logic [N-1:0]   TAPS_B    = 15'h100B,
  parameter logic [N-1:0]   SEED_A    = 15'h4000,
  parameter logic [N-1:0]   SEED_B    = 15'h2000,
  parameter int unsigned    EPOCH_LEN = 32767,
  parameter int unsigned    IDX_W     = 15,
  parameter int unsigned    DIV_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [N-1:0]     seed_b,
  input  logic [DIV_W-1:0] div,
  output logic             chip,
  output logic             chip_stb,
  output logic             epoch,
  output logic [IDX_W-1:0] chip_idx,
  output logic [N-1:0]     state_a,
  output logic [N-1:0]     state_b
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(EPOCH_LEN - 1);

  logic [N-1:0]     state_a_q, state_a_d;
  logic [N-1:0]     state_b_q, state_b_d;
  logic [N-1:0]     bseed_q, bseed_d;
  logic [IDX_W-1:0] chip_idx_q, chip_idx_d;
  logic [DIV_W-1:0] pcnt_q, pcnt_d;
  logic             chip_stb_q, chip_stb_d;
  logic             epoch_q, epoch_d;
  logic             advance;
  logic             wrap;

  // Shift right with the tap parity fed back into the MSB.
  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] x,
                                             input logic [N-1:0] taps);
    return {^(x & taps), x[N-1:1]};
  endfunction

  // Next-state: load beats advance; a zero B seed is replaced to avoid lock-up.
  always_comb begin
    state_a_d  = state_a_q;
    state_b_d  = state_b_q;
    bseed_d    = bseed_q;
    chip_idx_d = chip_idx_q;
    pcnt_d     = pcnt_q;
    chip_stb_d = 1'b0;
    epoch_d    = 1'b0;
    // >= so that lowering div below the running count fires at once.
    advance    = enable && (pcnt_q >= div);
    wrap       = (chip_idx_q == IDX_LAST);
    if (load) begin
      state_a_d  = SEED_A;
      bseed_d    = (seed_b == '0) ? SEED_B : seed_b;
      state_b_d  = (seed_b == '0) ? SEED_B : seed_b;
      chip_idx_d = '0;
      pcnt_d     = '0;
    end else if (advance) begin
      pcnt_d     = '0;
      chip_stb_d = 1'b1;
      if (wrap) begin
        state_a_d  = SEED_A;
        state_b_d  = bseed_q;
        chip_idx_d = '0;
        epoch_d    = 1'b1;
      end else begin
        state_a_d  = lfsr_step(state_a_q, TAPS_A);
        state_b_d  = lfsr_step(state_b_q, TAPS_B);
        chip_idx_d = chip_idx_q + 1'b1;
      end
    end else if (enable) begin
      pcnt_d = pcnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset to the seed values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_a_q  <= SEED_A;
      state_b_q  <= SEED_B;
      bseed_q    <= SEED_B;
      chip_idx_q <= '0;
      pcnt_q     <= '0;
      chip_stb_q <= 1'b0;
      epoch_q    <= 1'b0;
    end else begin
      state_a_q  <= state_a_d;
      state_b_q  <= state_b_d;
      bseed_q    <= bseed_d;
      chip_idx_q <= chip_idx_d;
      pcnt_q     <= pcnt_d;
      chip_stb_q <= chip_stb_d;
      epoch_q    <= epoch_d;
    end
  end

  assign chip     = state_a_q[0] ^ state_b_q[0];
  assign chip_stb = chip_stb_q;
  assign epoch    = epoch_q;
  assign chip_idx = chip_idx_q;
  assign state_a  = state_a_q;
  assign state_b  = state_b_q;

endmodule

// File: tb/tb_gold_code_gen.sv
// Directed bench for gold_code_gen: default instance plus a short-epoch
// instance (EPOCH_LEN=1023).
module tb_gold_code_gen;

  localparam logic [14:0] SA = 15'h4000;
  localparam logic [14:0] SB = 15'h2000;
  localparam logic [14:0] TA = 15'h0003;
  localparam logic [14:0] TB = 15'h100B;
  localparam int          EL = 32767;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // default instance controls/outputs
  logic        rst = 1'b1, en = 1'b0, ld = 1'b0;
  logic [14:0] sb = '0;
  logic [7:0]  dv = '0;
  logic        chip, stb, ep;
  logic [14:0] idx, sta, stb_b;

  // short-epoch instance controls/outputs
  logic        rst2 = 1'b1, en2 = 1'b0, ld2 = 1'b0;
  logic [14:0] sb2 = '0;
  logic [7:0]  dv2 = '0;
  logic        chip2, stb2, ep2;
  logic [9:0]  idx2;
  logic [14:0] sta2, stb_b2;

  gold_code_gen dut (
    .clk(clk), .reset(rst), .enable(en), .load(ld), .seed_b(sb), .div(dv),
    .chip(chip), .chip_stb(stb), .epoch(ep), .chip_idx(idx),
    .state_a(sta), .state_b(stb_b));

  gold_code_gen #(.EPOCH_LEN(1023), .IDX_W(10)) dut2 (
    .clk(clk), .reset(rst2), .enable(en2), .load(ld2), .seed_b(sb2), .div(dv2),
    .chip(chip2), .chip_stb(stb2), .epoch(ep2), .chip_idx(idx2),
    .state_a(sta2), .state_b(stb_b2));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference for the default instance.
  logic [14:0] m_a = SA, m_b = SB, m_bs = SB;
  int          m_idx = 0, m_pc = 0;
  logic        m_stb = 1'b0, m_ep = 1'b0;

  function automatic logic [14:0] lfsr(input logic [14:0] x, input logic [14:0] t);
    logic fb = 1'b0;
    for (int i = 0; i < 15; i++) if (t[i]) fb = fb ^ x[i];
    return {fb, x[14:1]};
  endfunction

  task automatic m_tick();
    if (rst) begin
      m_a = SA; m_b = SB; m_bs = SB; m_idx = 0; m_pc = 0; m_stb = 0; m_ep = 0;
    end else if (ld) begin
      m_bs = (sb == 15'd0) ? SB : sb;
      m_a = SA; m_b = m_bs; m_idx = 0; m_pc = 0; m_stb = 0; m_ep = 0;
    end else if (en && m_pc >= int'(dv)) begin
      m_pc = 0; m_stb = 1;
      if (m_idx == EL - 1) begin
        m_a = SA; m_b = m_bs; m_idx = 0; m_ep = 1;
      end else begin
        m_a = lfsr(m_a, TA); m_b = lfsr(m_b, TB); m_idx++; m_ep = 0;
      end
    end else begin
      if (en) m_pc++;
      m_stb = 0; m_ep = 0;
    end
  endtask

  // One clock: inputs set before the edge are sampled; outputs read 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
    m_tick();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_a"},   32'(sta),   32'(m_a));
    chk({tag, "_b"},   32'(stb_b), 32'(m_b));
    chk({tag, "_idx"}, 32'(idx),   32'(m_idx));
    chk({tag, "_stb"}, 32'(stb),   32'(m_stb));
    chk({tag, "_ep"},  32'(ep),    32'(m_ep));
  endtask

  logic [31:0] sig_d, sig_m;
  int n_stb, n_ep, cnt, last, maxi;
  logic [14:0] a0;
  logic [14:0] i0;
  logic seen;

  initial begin
    // ---- reset, enable low ----
    tick(); tick();
    rst = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_a", 32'(sta), 32'h4000);
    chk("rst_b", 32'(stb_b), 32'h2000);
    chk("rst_chip", 32'(chip), 0);
    chk("rst_idx", 32'(idx), 0);
    chk("rst_stb", 32'(stb), 0);
    chk("rst_ep", 32'(ep), 0);

    // ---- full period, div=0 ----
    en = 1; dv = 0;
    tick();
    chk("adv1_a", 32'(sta), 32'h2000);
    chk("adv1_b", 32'(stb_b), 32'h1000);
    chk("adv1_stb", 32'(stb), 1);
    chk("adv1_idx", 32'(idx), 1);
    sig_d = {sta, stb_b, chip, stb};
    sig_m = {m_a, m_b, m_a[0] ^ m_b[0], m_stb};
    n_stb = 1; n_ep = 0;
    for (int i = 1; i < EL; i++) begin
      tick();
      sig_d = {sig_d[30:0], sig_d[31]} ^ {sta, stb_b, chip, stb};
      sig_m = {sig_m[30:0], sig_m[31]} ^ {m_a, m_b, m_a[0] ^ m_b[0], m_stb};
      if (stb) n_stb++;
      if (ep) begin
        n_ep++;
        chk("wrap_a", 32'(sta), 32'h4000);
        chk("wrap_b", 32'(stb_b), 32'h2000);
        chk("wrap_idx", 32'(idx), 0);
      end
    end
    chk("full_sig", sig_d, sig_m);
    chk("full_nstb", n_stb, EL);
    chk("full_nep", n_ep, 1);

    // ---- div=3, enable gap, div change ----
    dv = 3;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("div3_stb", 32'(stb), (i % 4 == 3) ? 1 : 0);
    end
    tick(); tick();                    // prescaler now at 2
    a0 = sta; i0 = idx;
    en = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("frz_stb", 32'(stb), 0);
    end
    chk("frz_a", 32'(sta), 32'(a0));
    chk("frz_idx", 32'(idx), 32'(i0));
    en = 1;
    tick(); chk("res_stb0", 32'(stb), 0);
    tick(); chk("res_stb1", 32'(stb), 1);
    tick(); tick();                    // prescaler at 2 again
    dv = 1;
    tick(); chk("div31_stb", 32'(stb), 1);
    chk_model("div");

    // ---- load with advance due ----
    dv = 0; ld = 1; sb = 15'h0015;
    tick();
    chk("ld_a", 32'(sta), 32'h4000);
    chk("ld_b", 32'(stb_b), 32'h0015);
    chk("ld_idx", 32'(idx), 0);
    chk("ld_stb", 32'(stb), 0);
    ld = 0;
    tick();
    chk("ld_next_stb", 32'(stb), 1);
    chk("ld_next_a", 32'(sta), 32'h2000);
    cnt = 1; seen = 0;
    for (int i = 0; i < 40000 && !seen; i++) begin
      tick();
      if (stb) cnt++;
      if (ep) begin
        seen = 1;
        chk("ldwrap_b", 32'(stb_b), 32'h0015);
        chk("ldwrap_a", 32'(sta), 32'h4000);
        chk("ldwrap_cnt", cnt, EL);
      end
    end
    chk("ldwrap_seen", 32'(seen), 1);
    chk_model("ldrun");
    ld = 1; sb = 15'h0000;
    tick();
    chk("ld0_b", 32'(stb_b), 32'h2000);
    ld = 0;

    // ---- reset together with load, mid-epoch ----
    for (int i = 0; i < 7; i++) tick();
    rst = 1; ld = 1; sb = 15'h0123;
    tick();
    chk("rl_a", 32'(sta), 32'h4000);
    chk("rl_b", 32'(stb_b), 32'h2000);
    chk("rl_idx", 32'(idx), 0);
    chk("rl_stb", 32'(stb), 0);
    chk("rl_ep", 32'(ep), 0);
    rst = 0; ld = 0;
    tick();
    chk("rl_next_stb", 32'(stb), 1);
    chk_model("rl");
    en = 0;

    // ---- short-epoch instance ----
    rst2 = 0; en2 = 1; dv2 = 0;
    n_ep = 0; n_stb = 0; last = 0; maxi = 0;
    for (int t = 1; t <= 2046; t++) begin
      tick();
      if (stb2) n_stb++;
      if (int'(idx2) > maxi) maxi = int'(idx2);
      if (ep2) begin
        n_ep++;
        chk("e2_a", 32'(sta2), 32'h4000);
        chk("e2_idx", 32'(idx2), 0);
        chk("e2_spacing", t - last, 1023);
        last = t;
      end
    end
    chk("e2_nep", n_ep, 2);
    chk("e2_nstb", n_stb, 2046);
    chk("e2_maxidx", maxi, 1022);

    ld2 = 1; sb2 = 15'h0015;
    tick();
    chk("e2_ld_b", 32'(stb_b2), 32'h0015);
    for (int i = 0; i < 4; i++) begin
      ld2 = 0;
      tick();
    end
    rst2 = 1; ld2 = 1; sb2 = 15'h0123;
    tick();
    chk("e2_rl_b", 32'(stb_b2), 32'h2000);
    chk("e2_rl_idx", 32'(idx2), 0);
    chk("e2_rl_stb", 32'(stb2), 0);
    rst2 = 0; ld2 = 0;
    seen = 0;
    for (int i = 0; i < 1100 && !seen; i++) begin
      tick();
      if (ep2) begin
        seen = 1;
        chk("e2_bseed_b", 32'(stb_b2), 32'h2000);
        chk("e2_bseed_a", 32'(sta2), 32'h4000);
      end
    end
    chk("e2_bseed_seen", 32'(seen), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
